// File: rtl/riscv_pkg.sv
// Shared widths, types and helpers for the decode/execute pipeline slice.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CTRL_W-1:0]     ctrl_t;

    localparam reg_addr_t X0 = 5'd0;

    // x0 is hard-wired to zero, so a write to it never forwards anywhere.
    function automatic logic wb_hit(input logic we, input reg_addr_t wr, input reg_addr_t src);
        return we && (wr != X0) && (wr == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// Operand selection for one source: forces x0 to zero and forwards a same-cycle writeback.
module operand_bypass
    import riscv_pkg::*;
(
    input  reg_addr_t src_addr_i,
    input  xlen_t     rf_data_i,
    input  logic      wb_we_i,
    input  reg_addr_t wb_rd_i,
    input  xlen_t     wb_wd_i,
    output xlen_t     value_o
);

    // The register file does not force x0 and reads the pre-write value, so fix both here.
    always_comb begin
        value_o = {XLEN{1'b0}};
        if (src_addr_i == X0) begin
            value_o = {XLEN{1'b0}};
        end else if (wb_hit(wb_we_i, wb_rd_i, src_addr_i)) begin
            value_o = wb_wd_i;
        end else begin
            value_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with writeback bypass, stall-time operand refresh,
// flush and a saturating stall counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_wd,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0] stall_cnt
);

    logic      ex_valid_q, ex_valid_d;
    xlen_t     ex_pc_q, ex_pc_d;
    reg_addr_t ex_rs1_q, ex_rs1_d;
    reg_addr_t ex_rs2_q, ex_rs2_d;
    reg_addr_t ex_rd_q, ex_rd_d;
    xlen_t     ex_rs1_val_q, ex_rs1_val_d;
    xlen_t     ex_rs2_val_q, ex_rs2_val_d;
    xlen_t     ex_imm_q, ex_imm_d;
    ctrl_t     ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    xlen_t op1_s, op2_s;
    logic  load_s, stall_s;

    operand_bypass u_bypass_rs1 (
        .src_addr_i (id_rs1),
        .rf_data_i  (rf_rd1),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_wd_i    (wb_wd),
        .value_o    (op1_s)
    );

    operand_bypass u_bypass_rs2 (
        .src_addr_i (id_rs2),
        .rf_data_i  (rf_rd2),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_wd_i    (wb_wd),
        .value_o    (op2_s)
    );

    assign id_ready = !ex_valid_q || ex_ready;
    assign load_s   = id_valid && id_ready && !flush;
    assign stall_s  = ex_valid_q && !ex_ready && !flush;

    // Slot next-state: flush beats load, load beats drain, a stalled slot tracks writebacks.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_imm_d     = ex_imm_q;
        ex_ctrl_d    = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (load_s) begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = id_pc;
            ex_rs1_d     = id_rs1;
            ex_rs2_d     = id_rs2;
            ex_rd_d      = id_rd;
            ex_rs1_val_d = op1_s;
            ex_rs2_val_d = op2_s;
            ex_imm_d     = id_imm;
            ex_ctrl_d    = id_ctrl;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end else if (ex_valid_q) begin
            if (wb_hit(wb_we, wb_rd, ex_rs1_q)) begin
                ex_rs1_val_d = wb_wd;
            end else begin
                ex_rs1_val_d = ex_rs1_val_q;
            end
            if (wb_hit(wb_we, wb_rd, ex_rs2_q)) begin
                ex_rs2_val_d = wb_wd;
            end else begin
                ex_rs2_val_d = ex_rs2_val_q;
            end
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Stall counter sticks at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= {XLEN{1'b0}};
            ex_rs1_q     <= 5'd0;
            ex_rs2_q     <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_rs1_val_q <= {XLEN{1'b0}};
            ex_rs2_val_q <= {XLEN{1'b0}};
            ex_imm_q     <= {XLEN{1'b0}};
            ex_ctrl_q    <= {CTRL_W{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs1     = ex_rs1_q;
    assign ex_rs2     = ex_rs2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_rs1_val = ex_rs1_val_q;
    assign ex_rs2_val = ex_rs2_val_q;
    assign ex_imm     = ex_imm_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the model tracks architectural register contents and
// the single execute slot; a negedge monitor compares whatever the DUT presents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_imm, rf_rd1, rf_rd2, wb_wd;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [15:0] id_ctrl;
    logic        wb_we, flush, ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl;
    logic [31:0] stall_cnt;

    id_ex_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [15:0] ctrl;
    } txn_t;

    txn_t        q[$];
    logic [31:0] regs [32];
    logic        m_valid;
    logic [31:0] m_cnt;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake, counter and the presented instruction against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("id_ready", {63'd0, id_ready}, {63'd0, (!m_valid || ex_ready)});
            check("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
            check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
            if (m_valid) begin
                if (q.size() == 0) begin
                    check("scoreboard_nonempty", 64'd0, 64'd1);
                end else begin
                    check("ex_pc", {32'd0, ex_pc}, {32'd0, q[0].pc});
                    check("ex_rs1", {59'd0, ex_rs1}, {59'd0, q[0].rs1});
                    check("ex_rs2", {59'd0, ex_rs2}, {59'd0, q[0].rs2});
                    check("ex_rd", {59'd0, ex_rd}, {59'd0, q[0].rd});
                    check("ex_imm", {32'd0, ex_imm}, {32'd0, q[0].imm});
                    check("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, q[0].ctrl});
                    check("ex_rs1_val", {32'd0, ex_rs1_val}, {32'd0, regs[q[0].rs1]});
                    check("ex_rs2_val", {32'd0, ex_rs2_val}, {32'd0, regs[q[0].rs2]});
                    if (ex_ready && !flush) void'(q.pop_front());
                end
            end
        end
    end

    function automatic txn_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2);
        txn_t t;
        t.pc = pc; t.rs1 = rs1; t.rs2 = rs2;
        t.rd = 5'($urandom_range(0, 31));
        t.imm = $urandom;
        t.ctrl = 16'($urandom);
        return t;
    endfunction

    // One clock: drive at posedge+1, let the monitor look at negedge, then apply the cycle's effects.
    task automatic drive(input logic v, input txn_t t, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wd, input logic fl, input logic er);
        logic nxt_valid, ld, kill;
        logic [31:0] nxt_cnt;
        id_valid = v; id_pc = t.pc; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_imm = t.imm; id_ctrl = t.ctrl;
        rf_rd1 = (t.rs1 == 5'd0) ? $urandom : regs[t.rs1];
        rf_rd2 = (t.rs2 == 5'd0) ? $urandom : regs[t.rs2];
        wb_we = we; wb_rd = wrd; wb_wd = wd; flush = fl; ex_ready = er;
        ld = v && (!m_valid || er) && !fl;
        kill = fl;
        if (ld) q.push_back(t);
        if (fl)                 nxt_valid = 1'b0;
        else if (ld)            nxt_valid = 1'b1;
        else if (m_valid && er) nxt_valid = 1'b0;
        else                    nxt_valid = m_valid;
        nxt_cnt = (m_valid && !er && !fl && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
        @(posedge clk); #1;
        if (we && wrd != 5'd0) regs[wrd] = wd;
        if (kill) begin
            if (ld) q.delete();
            else q.delete();
        end
        m_valid = nxt_valid;
        m_cnt = nxt_cnt;
    endtask

    task automatic do_reset();
        rst = 1'b0; #1;
        check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_id_ready", {63'd0, id_ready}, 64'd1);
        check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        check("rst_fields", {ex_pc | ex_imm | ex_rs1_val | ex_rs2_val, 16'd0, ex_ctrl},
              64'd0);
        check("rst_addrs", {49'd0, ex_rs1, ex_rs2, ex_rd}, 64'd0);
        q.delete(); m_valid = 1'b0; m_cnt = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    txn_t t;
    initial begin
        rst = 1'b0; id_valid = 1'b0; id_pc = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_rd = 5'd0; id_imm = 32'd0; id_ctrl = 16'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_wd = 32'd0; flush = 1'b0; ex_ready = 1'b0;
        m_valid = 1'b0; m_cnt = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        regs[3] = 32'h11; regs[4] = 32'h22; regs[5] = 32'h5EED;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Plain flow.
        drive(1'b1, mk(32'h100, 5'd3, 5'd4), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("plain_rs1_val", {32'd0, ex_rs1_val}, 64'h11);
        check("plain_rs2_val", {32'd0, ex_rs2_val}, 64'h22);
        // Same-cycle bypass, then the x0 case.
        drive(1'b1, mk(32'h104, 5'd5, 5'd3), 1'b1, 5'd5, 32'hABCD, 1'b0, 1'b1);
        check("bypass_rs1_val", {32'd0, ex_rs1_val}, 64'hABCD);
        drive(1'b1, mk(32'h108, 5'd0, 5'd0), 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1);
        check("x0_rs1_val", {32'd0, ex_rs1_val}, 64'd0);

        // Stall with a refresh of x7 in the second stalled cycle.
        drive(1'b1, mk(32'h10C, 5'd2, 5'd7), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, mk(32'h200, 5'd1, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, mk(32'h204, 5'd1, 5'd1), 1'b1, 5'd7, 32'h55, 1'b0, 1'b0);
        check("refresh_rs2_val", {32'd0, ex_rs2_val}, 64'h55);
        drive(1'b1, mk(32'h208, 5'd1, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("stall_cnt_3", {32'd0, stall_cnt}, 64'd3);
        drive(1'b0, mk(32'h0, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Flush while loading.
        drive(1'b1, mk(32'h300, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, mk(32'h304, 5'd3, 5'd4), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
        drive(1'b0, mk(32'h0, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Back-to-back, ex_ready held high.
        for (int i = 0; i < 4; i++)
            drive(1'b1, mk(32'h400 + 32'(4 * i), 5'(i + 1), 5'(i + 2)), 1'b0, 5'd0, 32'd0,
                  1'b0, 1'b1);
        drive(1'b0, mk(32'h0, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Reset in the middle of a stall; the first cycle afterwards must accept.
        drive(1'b1, mk(32'h500, 5'd6, 5'd7), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, mk(32'h504, 5'd6, 5'd7), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, mk(32'h508, 5'd6, 5'd7), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("post_reset_load", {63'd0, ex_valid}, 64'd1);

        // Randomized traffic with tight register indices to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            t = mk($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            drive(1'($urandom_range(0, 3) != 0), t, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)));
            if (i == 300) do_reset();
        end
        drive(1'b0, mk(32'h0, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
